// File: rtl/probe_sr_serializer.sv
// Drains BIT_NUM/8 bytes from a standard (non-FWFT) FIFO and shifts them MSB-first
// into the SKIROC probe shift register through a divided serial clock.
module probe_sr_serializer #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned BIT_NUM = 1544
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start_In,
  input  logic       In_Ex_Fifo_Empty,
  input  logic [7:0] In_Ex_Fifo_Dout,
  output logic       Out_Ex_Fifo_Rd_En,
  output logic       Out_Sr_Ck,
  output logic       Out_Sr_In,
  output logic       Out_Sr_Rstb,
  output logic       Out_Busy,
  output logic       End_Flag
);

  localparam int unsigned DIV_W    = 9;
  localparam int unsigned TOT_W    = $clog2(BIT_NUM + 1);
  localparam int unsigned DIV_LAST = CLK_DIV - 1;
  localparam int unsigned RST_LAST = 2 * CLK_DIV - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SR_RST,
    S_FETCH,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_END
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_start_d;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [DIV_W-1:0]   w_div_nxt;
  logic [3:0]         r_bit_cnt;
  logic [3:0]         w_bit_nxt;
  logic [3:0]         w_bit_inc;
  logic [TOT_W-1:0]   r_tot_cnt;
  logic [TOT_W-1:0]   w_tot_nxt;
  logic [TOT_W-1:0]   w_tot_inc;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_nxt;
  logic               w_sr_in_nxt;
  logic               w_start_edge;

  // Delay flop resets high so a level held across reset is not seen as an edge.
  assign w_start_edge = Start_In && !r_start_d;
  assign w_bit_inc    = r_bit_cnt + 4'd1;
  assign w_tot_inc    = r_tot_cnt + TOT_W'(1);

  // Read strobe is decoded from the current state so it can never fire on an empty FIFO.
  assign Out_Ex_Fifo_Rd_En = (r_state == S_FETCH) && !In_Ex_Fifo_Empty;

  // State and output registers; outputs are decoded from the next state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_start_d   <= 1'b1;
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_tot_cnt   <= '0;
      r_shift     <= '0;
      Out_Sr_Ck   <= 1'b0;
      Out_Sr_In   <= 1'b0;
      Out_Sr_Rstb <= 1'b1;
      Out_Busy    <= 1'b0;
      End_Flag    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_start_d   <= Start_In;
      r_div_cnt   <= w_div_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_tot_cnt   <= w_tot_nxt;
      r_shift     <= w_shift_nxt;
      Out_Sr_Ck   <= (w_state_nxt == S_SHIFT_HI);
      Out_Sr_In   <= w_sr_in_nxt;
      Out_Sr_Rstb <= (w_state_nxt != S_SR_RST);
      Out_Busy    <= (w_state_nxt != S_IDLE);
      End_Flag    <= (w_state_nxt == S_END);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_tot_nxt   = r_tot_cnt;
    w_shift_nxt = r_shift;
    w_sr_in_nxt = Out_Sr_In;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt = S_SR_RST;
          w_div_nxt   = '0;
        end
      end
      S_SR_RST: begin
        if (r_div_cnt == DIV_W'(RST_LAST)) begin
          w_state_nxt = S_FETCH;
          w_div_nxt   = '0;
        end else begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end
      end
      S_FETCH: begin
        if (!In_Ex_Fifo_Empty) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        // Data is valid the cycle after the read strobe; bit 7 is presented immediately.
        w_shift_nxt = In_Ex_Fifo_Dout;
        w_sr_in_nxt = In_Ex_Fifo_Dout[7];
        w_bit_nxt   = '0;
        w_div_nxt   = '0;
        w_state_nxt = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (r_div_cnt == DIV_W'(DIV_LAST)) begin
          w_div_nxt   = '0;
          w_state_nxt = S_SHIFT_HI;
        end else begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end
      end
      S_SHIFT_HI: begin
        if (r_div_cnt == DIV_W'(DIV_LAST)) begin
          w_div_nxt   = '0;
          w_shift_nxt = {r_shift[6:0], 1'b0};
          w_bit_nxt   = w_bit_inc;
          w_tot_nxt   = w_tot_inc;
          if (w_bit_inc < 4'd8) begin
            w_state_nxt = S_SHIFT_LO;
            w_sr_in_nxt = r_shift[6];
          end else if (w_tot_inc == TOT_W'(BIT_NUM)) begin
            w_state_nxt = S_END;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end else begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end
      end
      S_END: begin
        w_div_nxt   = '0;
        w_bit_nxt   = '0;
        w_tot_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_probe_sr_serializer.sv
// Bench for probe_sr_serializer: one instance at CLK_DIV=4 and one at CLK_DIV=1, each fed
// by a FIFO model; received bits and timing are compared with values derived from the load rules.
module tb_probe_sr_serializer;

  localparam int NBYTES = 193;
  localparam int NBITS  = 1544;

  logic       clk = 1'b0;
  int         cyc = 0;
  logic [1:0] rst;
  logic [1:0] start;
  logic [1:0] stall;
  logic [1:0] empty;
  logic [7:0] dout [2];
  logic [1:0] rd_en, sr_ck, sr_in, sr_rstb, busy, endf;

  logic [7:0] mem [2][4096];
  int         wp [2];
  int         rp [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  probe_sr_serializer u_dut0 (
    .Clk(clk), .Rst(rst[0]), .Start_In(start[0]), .In_Ex_Fifo_Empty(empty[0]),
    .In_Ex_Fifo_Dout(dout[0]), .Out_Ex_Fifo_Rd_En(rd_en[0]), .Out_Sr_Ck(sr_ck[0]),
    .Out_Sr_In(sr_in[0]), .Out_Sr_Rstb(sr_rstb[0]), .Out_Busy(busy[0]), .End_Flag(endf[0])
  );

  probe_sr_serializer #(.CLK_DIV(1)) u_dut1 (
    .Clk(clk), .Rst(rst[1]), .Start_In(start[1]), .In_Ex_Fifo_Empty(empty[1]),
    .In_Ex_Fifo_Dout(dout[1]), .Out_Ex_Fifo_Rd_En(rd_en[1]), .Out_Sr_Ck(sr_ck[1]),
    .Out_Sr_In(sr_in[1]), .Out_Sr_Rstb(sr_rstb[1]), .Out_Busy(busy[1]), .End_Flag(endf[1])
  );

  // Standard FIFO model: data appears the cycle after the read strobe.
  assign empty[0] = stall[0] || (wp[0] == rp[0]);
  assign empty[1] = stall[1] || (wp[1] == rp[1]);

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en[k] && !empty[k]) begin
        dout[k] <= mem[k][rp[k] % 4096];
        rp[k]   <= rp[k] + 1;
      end
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int out_vec(input int k);
    return int'({rd_en[k], sr_ck[k], sr_in[k], sr_rstb[k], busy[k], endf[k]});
  endfunction

  // mode: 0 plain, 1 empty stall after byte 10, 2 extra start edges, 3 reset at cycle 3000
  task automatic run_load(input int k, input int d, input int pat, input int mode, input string tag);
    logic [7:0] exp_q [$];
    logic       rx [$];
    logic [7:0] b;
    int t0, rel, per, fetch11, exp_end, lim;
    int nrd, first_rd, nrise, rise_in_rst, nrstb, first_rstb, nbusy, nend, end_rel;
    int hold_bad, under, stall_bad, nbad;
    logic ck_prev, sin_prev;

    per     = 2 + 16 * d;
    fetch11 = 1 + 2 * d + 10 * per;
    exp_end = 1 + 2 * d + NBYTES * per + ((mode == 1) ? 50 : 0);
    lim     = exp_end + 20;
    for (int i = 0; i < NBYTES; i++) begin
      case (pat)
        0:       b = 8'(i);
        1:       b = 8'($urandom_range(0, 255));
        default: b = 8'hA5;
      endcase
      exp_q.push_back(b);
      mem[k][wp[k] % 4096] = b;
      wp[k]++;
    end
    nrd = 0; first_rd = -1; nrise = 0; rise_in_rst = 0; nrstb = 0; first_rstb = -1;
    nbusy = 0; nend = 0; end_rel = -1; hold_bad = 0; under = 0; stall_bad = 0;
    ck_prev = sr_ck[k]; sin_prev = sr_in[k];

    @(posedge clk); #1;
    t0 = cyc;
    start[k] = 1'b1;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (rd_en[k]) begin
        if (empty[k]) under++;
        nrd++;
        if (first_rd < 0) first_rd = rel;
      end
      if (sr_ck[k] && !ck_prev) begin
        rx.push_back(sr_in[k]);
        nrise++;
        if (!sr_rstb[k]) rise_in_rst++;
      end
      if (sr_ck[k] && ck_prev && (sr_in[k] != sin_prev)) hold_bad++;
      if (stall[k] && rel >= fetch11 && (rd_en[k] || sr_ck[k] || sr_in[k] != sin_prev)) stall_bad++;
      if (!sr_rstb[k]) begin
        nrstb++;
        if (first_rstb < 0) first_rstb = rel;
      end
      if (busy[k]) nbusy++;
      if (endf[k]) begin
        nend++;
        end_rel = rel;
      end
      ck_prev  = sr_ck[k];
      sin_prev = sr_in[k];
      if (mode == 3 && rel == 3001) begin
        check_val({tag, "_rst_outs"}, out_vec(k), 6'b000100);
        break;
      end
      if (end_rel >= 0 && rel >= end_rel + 2) break;
      @(posedge clk); #1;
      rel = cyc - t0;
      start[k] = (mode == 2) && (rel == 100 || rel == 5000);
      stall[k] = (mode == 1) && (rel >= fetch11) && (rel < fetch11 + 50);
      rst[k]   = (mode == 3) && (rel == 3000);
    end
    start[k] = 1'b0;
    stall[k] = 1'b0;
    rst[k]   = 1'b0;

    if (mode == 3) begin
      check_val({tag, "_rd_before_rst"}, int'(nrd > 0), 1);
      wp[k] = rp[k];
      return;
    end

    nbad = 0;
    for (int i = 0; i < NBYTES; i++) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++)
        if (8 * i + j < rx.size()) b = {b[6:0], rx[8 * i + j]};
      if (b != exp_q[i]) nbad++;
    end
    check_val({tag, "_rstb_first"}, first_rstb, 1);
    check_val({tag, "_rstb_len"},   nrstb, 2 * d);
    check_val({tag, "_ck_in_rst"},  rise_in_rst, 0);
    check_val({tag, "_first_rd"},   first_rd, 1 + 2 * d);
    check_val({tag, "_rd_cnt"},     nrd, NBYTES);
    check_val({tag, "_ck_rise"},    nrise, NBITS);
    check_val({tag, "_end_cnt"},    nend, 1);
    check_val({tag, "_end_cyc"},    end_rel, exp_end);
    check_val({tag, "_busy_cyc"},   nbusy, exp_end);
    check_val({tag, "_hold"},       hold_bad, 0);
    check_val({tag, "_underflow"},  under, 0);
    check_val({tag, "_bad_bytes"},  nbad, 0);
    if (mode == 1) check_val({tag, "_stall_quiet"}, stall_bad, 0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst = 2'b11; start = 2'b10; stall = 2'b00;
    wp[0] = 0; wp[1] = 0; rp[0] = 0; rp[1] = 0;
    dout[0] = 8'h00; dout[1] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_dut0", out_vec(0), 6'b000100);
    check_val("reset_dut1", out_vec(1), 6'b000100);
    @(posedge clk); #1;
    rst = 2'b00;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_val("held_start_busy", int'(busy[1]), 0);
    check_val("held_start_rstb", int'(sr_rstb[1]), 1);
    start[1] = 1'b0;
    repeat (3) @(posedge clk);

    run_load(0, 4, 0, 0, "default");
    run_load(0, 4, 1, 1, "stall");
    run_load(0, 4, 1, 2, "busy_start");
    run_load(0, 4, 1, 3, "midreset");
    repeat (3) @(posedge clk);
    run_load(0, 4, 1, 0, "fresh");
    run_load(1, 1, 2, 0, "div1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
